osd_mixer_pipe: RTL

//  Parametrised, pipelined OSD overlay/mixer: successor to the fixed 8-bit OSD overlay. Sits between the

---
 rtl/osd_mixer_pipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/osd_mixer_pipe.sv
// OSD overlay/mixer: merges osd_window/osd_pixel onto video, with frame-latched mix mode and scanline dimming.
// Latency is 2 pix_en cycles for colour, syncs and window; pix_en low freezes every register (no backpressure).
module osd_mixer_pipe #(
    parameter int          COLOR_W  = 8,
    parameter logic        SYNC_POL = 1'b0,
    parameter logic [23:0] OSD_FG   = 24'hFFFFFF,
    parameter logic [23:0] OSD_BG   = 24'h0000C0,
    parameter int          SCAN_DIM = 1
) (
    input  logic               sys_clk_i,
    input  logic               sys_rst_i,
    input  logic               pix_en,
    input  logic [COLOR_W-1:0] red_in,
    input  logic [COLOR_W-1:0] green_in,
    input  logic [COLOR_W-1:0] blue_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               window_in,
    input  logic               osd_window_in,
    input  logic               osd_pixel_in,
    input  logic [1:0]         mode_req,
    input  logic               scanline_ena,
    output logic [COLOR_W-1:0] red_out,
    output logic [COLOR_W-1:0] green_out,
    output logic [COLOR_W-1:0] blue_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               window_out,
    output logic [1:0]         mode_active
);

    // Top COLOR_W bits of an 8-bit channel, zero-padded below when COLOR_W > 8.
    function automatic logic [COLOR_W-1:0] chan(input logic [7:0] c8);
        logic [COLOR_W+7:0] ext;
        ext = {c8, {COLOR_W{1'b0}}};
        return ext[COLOR_W+7 -: COLOR_W];
    endfunction

    localparam logic [COLOR_W-1:0] FG_R = chan(OSD_FG[23:16]);
    localparam logic [COLOR_W-1:0] FG_G = chan(OSD_FG[15:8]);
    localparam logic [COLOR_W-1:0] FG_B = chan(OSD_FG[7:0]);
    localparam logic [COLOR_W-1:0] BG_R = chan(OSD_BG[23:16]);
    localparam logic [COLOR_W-1:0] BG_G = chan(OSD_BG[15:8]);
    localparam logic [COLOR_W-1:0] BG_B = chan(OSD_BG[7:0]);

    function automatic logic [COLOR_W-1:0] mix(
        input logic [COLOR_W-1:0] v,
        input logic [COLOR_W-1:0] f,
        input logic [COLOR_W-1:0] b,
        input logic               osd_w,
        input logic               osd_p,
        input logic [1:0]         mode,
        input logic               dim
    );
        logic [COLOR_W-1:0] m;
        m = v;
        if (osd_w) begin
            case (mode)
                2'd1:    m = osd_p ? f : b;
                2'd2:    m = osd_p ? f : COLOR_W'(({1'b0, v} + {1'b0, b}) >> 1);
                2'd3:    m = osd_p ? f : (v >> 1);
                default: m = v;
            endcase
        end
        // Dimming applies after the mix so OSD pixels on odd lines darken too.
        if (dim) begin
            m = (SCAN_DIM == 0) ? (m >> 1) : (m - (m >> 2));
        end
        return m;
    endfunction

    logic [COLOR_W-1:0] red_s1, green_s1, blue_s1;
    logic               hsync_s1, vsync_s1, window_s1, osd_window_s1, osd_pixel_s1;
    logic               scan_shadow, parity;
    logic               hs_edge, vs_edge, dim;

    assign hs_edge = (hsync_in == SYNC_POL) && (hsync_s1 != SYNC_POL);
    assign vs_edge = (vsync_in == SYNC_POL) && (vsync_s1 != SYNC_POL);
    assign dim     = scan_shadow & parity;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            red_s1        <= '0;
            green_s1      <= '0;
            blue_s1       <= '0;
            hsync_s1      <= ~SYNC_POL;
            vsync_s1      <= ~SYNC_POL;
            window_s1     <= 1'b0;
            osd_window_s1 <= 1'b0;
            osd_pixel_s1  <= 1'b0;
            mode_active   <= 2'd0;
            scan_shadow   <= 1'b0;
            parity        <= 1'b0;
            red_out       <= '0;
            green_out     <= '0;
            blue_out      <= '0;
            hsync_out     <= ~SYNC_POL;
            vsync_out     <= ~SYNC_POL;
            window_out    <= 1'b0;
        end else if (pix_en) begin
            red_s1        <= red_in;
            green_s1      <= green_in;
            blue_s1       <= blue_in;
            hsync_s1      <= hsync_in;
            vsync_s1      <= vsync_in;
            window_s1     <= window_in;
            osd_window_s1 <= osd_window_in;
            osd_pixel_s1  <= osd_pixel_in;

            // vsync edge takes priority so a coincident hsync edge still starts the frame on parity 0.
            if (vs_edge) begin
                mode_active <= mode_req;
                scan_shadow <= scanline_ena;
                parity      <= 1'b0;
            end else if (hs_edge) begin
                parity <= ~parity;
            end

            red_out    <= window_s1 ? mix(red_s1,   FG_R, BG_R, osd_window_s1, osd_pixel_s1, mode_active, dim) : '0;
            green_out  <= window_s1 ? mix(green_s1, FG_G, BG_G, osd_window_s1, osd_pixel_s1, mode_active, dim) : '0;
            blue_out   <= window_s1 ? mix(blue_s1,  FG_B, BG_B, osd_window_s1, osd_pixel_s1, mode_active, dim) : '0;
            hsync_out  <= hsync_s1;
            vsync_out  <= vsync_s1;
            window_out <= window_s1;
        end
    end

endmodule
